ram_arbiter: RTL

//  Shares the board's asynchronous cellular RAM between two requesters.

---
 rtl/ram_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter and async-mode cellular RAM pin sequencer
//
// Shares one asynchronous PSRAM between port A (sample loader) and port B
// (playback voice). Each access runs IDLE -> SETUP -> ACCESS x ACCESS_CYCLES -> HOLD.
// All pins and acks are registered from the next-state decode, so there is no
// combinational path from a request to a pin.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   a_req/a_we/a_be/a_addr    port A request, write flag, byte enables {UB,LB}, word address
//   a_wdata, a_ack, a_rdata   port A write data, one-cycle completion pulse, read data
//   b_*                       same set for port B
//   busy                      high whenever the sequencer is not idle
//   MemDB                     bidirectional RAM data bus
//   MemAdv, MemClk            tied low (async mode)
//   RamCS, MemOE, MemWR       chip select, output enable, write enable (active-low)
//   RamLB, RamUB              byte lane enables (active-low)
//   MemAdr[26:1]              word address pins
module ram_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int ADDR_W        = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic              busy,
  inout  wire  [15:0]       MemDB,
  output logic              MemAdv,
  output logic              MemClk,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB,
  output logic [26:1]       MemAdr
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t state, next_state;

  // Latched transaction; gnt_b/last_b: 1 = port B
  logic              gnt_b;
  logic              last_b;
  logic              lat_we;
  logic [1:0]        lat_be;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              db_oe;

  // Arbitration result and the transaction currently being sequenced
  logic              arb_valid;
  logic              arb_b;
  logic              sel_b;
  logic              sel_we;
  logic [1:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;

  // Next values of the registered outputs
  logic              cs_d, oe_d, wr_d, lb_d, ub_d, db_oe_d;
  logic              a_ack_d, b_ack_d, busy_d;
  logic [26:1]       adr_d;

  assign MemAdv = 1'b0;
  assign MemClk = 1'b0;
  assign MemDB  = db_oe ? lat_wdata : 16'hzzzz;

  // Round-robin: on a tie the port that did not go last wins
  assign arb_valid = a_req | b_req;
  assign arb_b     = b_req & (~a_req | ~last_b);

  // In IDLE the pins for SETUP are computed from the winning request directly,
  // since the latch registers load on the same edge.
  always_comb begin
    sel_b     = gnt_b;
    sel_we    = lat_we;
    sel_be    = lat_be;
    sel_addr  = lat_addr;
    sel_wdata = lat_wdata;
    if (state == IDLE) begin
      sel_b     = arb_b;
      sel_we    = arb_b ? b_we    : a_we;
      sel_be    = arb_b ? b_be    : a_be;
      sel_addr  = arb_b ? b_addr  : a_addr;
      sel_wdata = arb_b ? b_wdata : a_wdata;
    end
  end

  // State register plus registered outputs and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_b     <= 1'b0;
      last_b    <= 1'b1;
      lat_we    <= 1'b0;
      lat_be    <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= 16'h0000;
      cnt       <= '0;
      db_oe     <= 1'b0;
      RamCS     <= 1'b1;
      MemOE     <= 1'b1;
      MemWR     <= 1'b1;
      RamLB     <= 1'b1;
      RamUB     <= 1'b1;
      MemAdr    <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      busy      <= 1'b0;
      a_rdata   <= 16'h0000;
      b_rdata   <= 16'h0000;
    end else begin
      state  <= next_state;
      db_oe  <= db_oe_d;
      RamCS  <= cs_d;
      MemOE  <= oe_d;
      MemWR  <= wr_d;
      RamLB  <= lb_d;
      RamUB  <= ub_d;
      MemAdr <= adr_d;
      a_ack  <= a_ack_d;
      b_ack  <= b_ack_d;
      busy   <= busy_d;

      if (state == IDLE && arb_valid) begin
        gnt_b     <= arb_b;
        lat_we    <= sel_we;
        lat_be    <= sel_be;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end

      if (state == SETUP) begin
        cnt <= CNT_W'(ACCESS_CYCLES - 1);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Read data is sampled on the edge that closes the last OE-low cycle
      if (state == ACCESS && cnt == '0 && !lat_we) begin
        if (gnt_b) begin
          b_rdata <= MemDB;
        end else begin
          a_rdata <= MemDB;
        end
      end

      if (state == HOLD) begin
        last_b <= gnt_b;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_valid) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (cnt == '0) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pin values for the cycle we are about to enter. Write data is driven from
  // SETUP through HOLD; OE only ever falls on reads, so the bus never contends.
  always_comb begin
    cs_d    = 1'b1;
    oe_d    = 1'b1;
    wr_d    = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    db_oe_d = 1'b0;
    adr_d   = MemAdr;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    busy_d  = (next_state != IDLE);
    case (next_state)
      SETUP: begin
        cs_d    = 1'b0;
        adr_d   = 26'(sel_addr);
        lb_d    = sel_we ? ~sel_be[0] : 1'b0;
        ub_d    = sel_we ? ~sel_be[1] : 1'b0;
        db_oe_d = sel_we;
      end
      ACCESS: begin
        cs_d    = 1'b0;
        oe_d    = sel_we;
        wr_d    = ~sel_we;
        lb_d    = sel_we ? ~sel_be[0] : 1'b0;
        ub_d    = sel_we ? ~sel_be[1] : 1'b0;
        db_oe_d = sel_we;
      end
      HOLD: begin
        db_oe_d = sel_we;
        a_ack_d = ~sel_b;
        b_ack_d = sel_b;
      end
      default: ;
    endcase
  end

endmodule
